// File: rtl/riscv.sv
// Privilege-level encodings shared by the core-facing trace logic.
// Latency: none (type definitions only).
// Backpressure: none (type definitions only).
package riscv;

    typedef enum logic [1:0] {
        PRIV_LVL_U = 2'b00,
        PRIV_LVL_S = 2'b01,
        PRIV_LVL_M = 2'b11
    } priv_lvl_t;

endpackage

// File: rtl/rvfi_pkg.sv
// RVFI commit record as seen on each core commit port.
// Latency: none (type definitions only).
// Backpressure: none (type definitions only).
package rvfi_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] order;
        logic [31:0] insn;
        logic        trap;
        logic [1:0]  mode;
        logic [63:0] pc_rdata;
    } rvfi_instr_t;

endpackage

// File: rtl/rvfi_commit_serializer.sv
// Packs multi-port RVFI commits into one in-order trace stream and signals end-of-test.
// Latency: an entry written at edge N is presented on trace_o at cycle N+1; no bypass.
// Backpressure: trace_ready_i stalls the head; the core is never stalled, a batch that does not fit is dropped whole.
module rvfi_commit_serializer #(
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned DEPTH           = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 2000000
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  rvfi_pkg::rvfi_instr_t [NR_COMMIT_PORTS-1:0] rvfi_i,
    output rvfi_pkg::rvfi_instr_t                      trace_o,
    output logic                                       trace_valid_o,
    input  logic                                       trace_ready_i,
    output logic                                       overflow_o,
    output logic [15:0]                                drop_cnt_o,
    output logic                                       finish_o,
    output logic                                       timeout_o
);

    localparam int          PTR_W    = $clog2(DEPTH);
    localparam int          CNT_W    = $clog2(DEPTH + 1);
    localparam logic [31:0] ECALL    = 32'h0000_0073;
    localparam logic [31:0] CYC_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    state_e                state_q, state_d;
    rvfi_pkg::rvfi_instr_t mem_q [DEPTH];
    logic [PTR_W-1:0]      wptr_q, rptr_q;
    logic [CNT_W-1:0]      count_q;
    logic [31:0]           cyc_q;
    logic                  overflow_q;
    logic [15:0]           drop_cnt_q;
    logic                  timeout_q;

    logic [NR_COMMIT_PORTS-1:0] incl;
    logic [PTR_W-1:0]           off [NR_COMMIT_PORTS];
    logic [CNT_W-1:0]           n_act;
    logic [CNT_W-1:0]           free;
    logic                       halt_seen;
    logic                       run;
    logic                       drop;
    logic                       push;
    logic                       pop;
    logic                       to_hit;
    logic [16:0]                drop_sum;

    assign trace_valid_o = (count_q != '0);
    assign trace_o       = trace_valid_o ? mem_q[rptr_q] : '0;
    assign overflow_o    = overflow_q;
    assign drop_cnt_o    = drop_cnt_q;
    assign finish_o      = (state_q == ST_DONE);
    assign timeout_o     = timeout_q;

    // Select active ports up to and including the first halt, and give each a packed FIFO slot offset.
    always_comb begin
        incl      = '0;
        halt_seen = 1'b0;
        n_act     = '0;
        for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
            off[i] = n_act[PTR_W-1:0];
            if (!halt_seen && (rvfi_i[i].valid || rvfi_i[i].trap)) begin
                incl[i] = 1'b1;
                n_act   = n_act + CNT_W'(1);
            end
            if (!halt_seen && rvfi_i[i].valid && (rvfi_i[i].insn == ECALL) &&
                (rvfi_i[i].mode == riscv::PRIV_LVL_M)) begin
                halt_seen = 1'b1;
            end
        end
    end

    // Push/drop decision uses occupancy at the start of the cycle; a same-cycle pop earns no credit.
    always_comb begin
        run      = (state_q == ST_RUN);
        free     = CNT_W'(DEPTH) - count_q;
        drop     = run && (n_act > free);
        push     = run && !drop && (n_act != '0);
        pop      = trace_valid_o && trace_ready_i;
        to_hit   = run && (TIMEOUT_CYCLES != 0) && (cyc_q == CYC_LAST) && !halt_seen;
        drop_sum = {1'b0, drop_cnt_q} + 17'(n_act);
    end

    // End-of-test sequencing: halt or timeout leaves RUN, DRAIN waits for the last pop.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (run && (halt_seen || to_hit)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((count_q == '0) || ((count_q == CNT_W'(1)) && pop)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_RUN;
        endcase
    end

    // Control state: FSM, pointers, occupancy, cycle counter and sticky drop statistics.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_RUN;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            cyc_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_q + (push ? n_act : '0) - (pop ? CNT_W'(1) : '0);
            if (push) begin
                wptr_q <= wptr_q + n_act[PTR_W-1:0];
            end
            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            if (run) begin
                cyc_q <= cyc_q + 32'd1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
                drop_cnt_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end
            if (to_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // Entry storage: each included port lands in its packed slot after the write pointer.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < int'(NR_COMMIT_PORTS); i++) begin
            if (push && incl[i]) begin
                mem_q[wptr_q + off[i]] <= rvfi_i[i];
            end
        end
    end

endmodule

// File: tb/tb_rvfi_commit_serializer.sv
// Self-checking bench for rvfi_commit_serializer: ordering, overflow, halt, timeout and reset.
// Latency: checks entries one cycle after commit, finish one cycle after the final pop.
// Backpressure: drives trace_ready_i low to fill the FIFO and high to drain it.
module tb_rvfi_commit_serializer;

    localparam logic [31:0] ECALL = 32'h0000_0073;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: default timeout, never reached here.
    logic                            rst;
    logic                            rdy;
    rvfi_pkg::rvfi_instr_t [1:0]     rvfi;
    rvfi_pkg::rvfi_instr_t           trace;
    logic                            vld;
    logic                            ovf;
    logic [15:0]                     drop;
    logic                            fin;
    logic                            tmo;

    // Short-timeout instance for end-of-test timing.
    logic                            rst_t;
    logic                            rdy_t;
    rvfi_pkg::rvfi_instr_t [1:0]     rvfi_t;
    rvfi_pkg::rvfi_instr_t           tr_t;
    logic                            vld_t;
    logic                            ovf_t;
    logic [15:0]                     drop_t;
    logic                            fin_t;
    logic                            tmo_t;

    rvfi_commit_serializer #(.NR_COMMIT_PORTS(2), .DEPTH(16)) dut (
        .clk_i(clk), .rst_i(rst), .rvfi_i(rvfi), .trace_o(trace),
        .trace_valid_o(vld), .trace_ready_i(rdy), .overflow_o(ovf),
        .drop_cnt_o(drop), .finish_o(fin), .timeout_o(tmo)
    );

    rvfi_commit_serializer #(.NR_COMMIT_PORTS(2), .DEPTH(16), .TIMEOUT_CYCLES(10)) dut_to (
        .clk_i(clk), .rst_i(rst_t), .rvfi_i(rvfi_t), .trace_o(tr_t),
        .trace_valid_o(vld_t), .trace_ready_i(rdy_t), .overflow_o(ovf_t),
        .drop_cnt_o(drop_t), .finish_o(fin_t), .timeout_o(tmo_t)
    );

    int vectors = 0;
    int errs    = 0;
    rvfi_pkg::rvfi_instr_t exp_q [$];

    function automatic rvfi_pkg::rvfi_instr_t mk(input int tag, input logic [31:0] insn,
                                                 input logic [1:0] mode);
        rvfi_pkg::rvfi_instr_t r;
        r          = '0;
        r.valid    = 1'b1;
        r.order    = 64'(tag);
        r.insn     = insn;
        r.mode     = mode;
        r.pc_rdata = 64'h8000_0000 + 64'(tag * 4);
        return r;
    endfunction

    function automatic rvfi_pkg::rvfi_instr_t mk_trap(input int tag);
        rvfi_pkg::rvfi_instr_t r;
        r          = mk(tag, NOP, 2'b11);
        r.valid    = 1'b0;
        r.trap     = 1'b1;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every handshake on the main instance must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && vld && rdy) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL sb_unexpected_pop got order=%0d want no entry", trace.order);
            end else begin
                rvfi_pkg::rvfi_instr_t e;
                e = exp_q.pop_front();
                if (trace !== e) begin
                    errs++;
                    $display("FAIL sb_entry got order=%0d insn=%h want order=%0d insn=%h",
                             trace.order, trace.insn, e.order, e.insn);
                end
            end
        end
    end

    task automatic do_reset();
        rdy  = 1'b0;
        rvfi = '0;
        rst  = 1'b1;
        tick();
        rst  = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b0; rvfi = '0;
        rst_t = 1'b1; rdy_t = 1'b0; rvfi_t = '0;
        tick();
        tick();
        vectors++; if (vld !== 1'b0) begin errs++; $display("FAIL rst_valid got %b want 0", vld); end
        vectors++; if (trace !== '0) begin errs++; $display("FAIL rst_trace got %h want 0", trace); end
        vectors++; if (ovf !== 1'b0) begin errs++; $display("FAIL rst_overflow got %b want 0", ovf); end
        vectors++; if (drop !== 16'd0) begin errs++; $display("FAIL rst_drop got %0d want 0", drop); end
        vectors++; if (fin !== 1'b0) begin errs++; $display("FAIL rst_finish got %b want 0", fin); end
        vectors++; if (tmo !== 1'b0) begin errs++; $display("FAIL rst_timeout got %b want 0", tmo); end
        rst = 1'b0;
        rst_t = 1'b0;
    endtask

    task automatic test_ordering();
        int want [4] = '{1, 2, 3, 4};
        do_reset();
        rdy = 1'b1;
        rvfi[0] = '0; rvfi[1] = mk(1, NOP, 2'b11);
        exp_q.push_back(rvfi[1]);
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k == 0) begin
                rvfi[0] = mk(2, NOP, 2'b11); rvfi[1] = mk(3, NOP, 2'b11);
                exp_q.push_back(rvfi[0]); exp_q.push_back(rvfi[1]);
            end else if (k == 1) begin
                rvfi[0] = mk(4, NOP, 2'b11); rvfi[1] = '0;
                exp_q.push_back(rvfi[0]);
            end else begin
                rvfi = '0;
            end
            vectors++;
            if (vld !== 1'b1 || trace.order !== 64'(want[k])) begin
                errs++;
                $display("FAIL order_seq[%0d] got vld=%b order=%0d want vld=1 order=%0d",
                         k, vld, trace.order, want[k]);
            end
        end
        tick();
        vectors++; if (vld !== 1'b0) begin errs++; $display("FAIL order_empty got %b want 0", vld); end
        vectors++; if (ovf !== 1'b0) begin errs++; $display("FAIL order_overflow got %b want 0", ovf); end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            rvfi[0] = mk(10 + 2 * c, NOP, 2'b11);
            rvfi[1] = mk(11 + 2 * c, NOP, 2'b11);
            if (c < 8) begin
                exp_q.push_back(rvfi[0]); exp_q.push_back(rvfi[1]);
            end
            tick();
            if (c == 7) begin
                vectors++; if (drop !== 16'd0) begin errs++; $display("FAIL bp_full_drop got %0d want 0", drop); end
                vectors++; if (trace.order !== 64'd10) begin errs++; $display("FAIL bp_hold got %0d want 10", trace.order); end
            end
        end
        rvfi = '0;
        vectors++; if (drop !== 16'd2) begin errs++; $display("FAIL bp_drop got %0d want 2", drop); end
        vectors++; if (ovf !== 1'b1) begin errs++; $display("FAIL bp_overflow got %b want 1", ovf); end
        rdy = 1'b1;
        for (int c = 0; c < 16; c++) tick();
        vectors++; if (vld !== 1'b0) begin errs++; $display("FAIL bp_drained got %b want 0", vld); end
        vectors++; if (exp_q.size() != 0) begin errs++; $display("FAIL bp_left got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int c = 0; c < 8; c++) begin
            rvfi[0] = mk(40 + 2 * c, NOP, 2'b11);
            rvfi[1] = (c < 7) ? mk(41 + 2 * c, NOP, 2'b11) : '0;
            exp_q.push_back(rvfi[0]);
            if (c < 7) exp_q.push_back(rvfi[1]);
            tick();
        end
        rdy = 1'b1;
        rvfi[0] = mk(70, NOP, 2'b11); rvfi[1] = mk(71, NOP, 2'b11);
        tick();
        rvfi = '0;
        vectors++; if (drop !== 16'd2) begin errs++; $display("FAIL fp_drop got %0d want 2", drop); end
        vectors++; if (ovf !== 1'b1) begin errs++; $display("FAIL fp_overflow got %b want 1", ovf); end
        vectors++; if (trace.order !== 64'd41) begin errs++; $display("FAIL fp_head got %0d want 41", trace.order); end
        for (int c = 0; c < 14; c++) tick();
        vectors++; if (vld !== 1'b0) begin errs++; $display("FAIL fp_drained got %b want 0", vld); end
        vectors++; if (exp_q.size() != 0) begin errs++; $display("FAIL fp_left got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_halt();
        do_reset();
        rvfi[0] = mk(100, NOP, 2'b11); rvfi[1] = mk_trap(101);
        exp_q.push_back(rvfi[0]); exp_q.push_back(rvfi[1]);
        tick();
        rvfi[0] = mk(102, NOP, 2'b11); rvfi[1] = '0;
        exp_q.push_back(rvfi[0]);
        tick();
        rdy = 1'b1;
        rvfi[0] = mk(103, ECALL, 2'b11); rvfi[1] = mk(104, NOP, 2'b11);
        exp_q.push_back(rvfi[0]);
        tick();
        rvfi[0] = mk(200, NOP, 2'b11); rvfi[1] = mk(201, NOP, 2'b11);
        tick();
        tick();
        vectors++; if (fin !== 1'b0) begin errs++; $display("FAIL halt_early_finish got %b want 0", fin); end
        tick();
        vectors++; if (fin !== 1'b1) begin errs++; $display("FAIL halt_finish got %b want 1", fin); end
        vectors++; if (tmo !== 1'b0) begin errs++; $display("FAIL halt_timeout got %b want 0", tmo); end
        vectors++; if (drop !== 16'd0) begin errs++; $display("FAIL halt_drop got %0d want 0", drop); end
        vectors++; if (vld !== 1'b0) begin errs++; $display("FAIL halt_valid got %b want 0", vld); end
        for (int c = 0; c < 3; c++) tick();
        vectors++; if (fin !== 1'b1 || vld !== 1'b0) begin errs++; $display("FAIL halt_done_hold got fin=%b vld=%b want fin=1 vld=0", fin, vld); end
        vectors++; if (exp_q.size() != 0) begin errs++; $display("FAIL halt_left got %0d want 0", exp_q.size()); end
        rvfi = '0;
    endtask

    task automatic test_reset_mid_drain();
        rst_t = 1'b1; tick(); rst_t = 1'b0;
        rdy_t = 1'b0;
        rvfi_t[0] = mk(300, NOP, 2'b11); rvfi_t[1] = mk(301, NOP, 2'b11); tick();
        rvfi_t[0] = mk(302, NOP, 2'b11); rvfi_t[1] = mk(303, NOP, 2'b11); tick();
        rvfi_t[0] = mk(304, ECALL, 2'b11); rvfi_t[1] = '0; tick();
        rvfi_t = '0;
        tick(); tick();
        vectors++; if (vld_t !== 1'b1 || tr_t.order !== 64'd300) begin errs++; $display("FAIL rmd_queued got vld=%b order=%0d want vld=1 order=300", vld_t, tr_t.order); end
        vectors++; if (fin_t !== 1'b0) begin errs++; $display("FAIL rmd_pre_finish got %b want 0", fin_t); end
        rst_t = 1'b1; tick(); rst_t = 1'b0;
        vectors++; if (vld_t !== 1'b0) begin errs++; $display("FAIL rmd_valid got %b want 0", vld_t); end
        vectors++; if (tr_t !== '0) begin errs++; $display("FAIL rmd_trace got %h want 0", tr_t); end
        vectors++; if (fin_t !== 1'b0) begin errs++; $display("FAIL rmd_finish got %b want 0", fin_t); end
        vectors++; if (drop_t !== 16'd0 || ovf_t !== 1'b0) begin errs++; $display("FAIL rmd_drop got %0d/%b want 0/0", drop_t, ovf_t); end
    endtask

    // Runs straight after the reset in test_reset_mid_drain: finish timing proves cyc restarted.
    task automatic test_timeout();
        rdy_t = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            rvfi_t = '0;
            if (k == 3) rvfi_t[0] = mk(305, ECALL, 2'b00);
            tick();
            if (k == 3) begin
                vectors++; if (vld_t !== 1'b1 || tr_t.order !== 64'd305) begin errs++; $display("FAIL to_uecall got vld=%b order=%0d want vld=1 order=305", vld_t, tr_t.order); end
            end
            if (k <= 10) begin
                vectors++; if (fin_t !== 1'b0) begin errs++; $display("FAIL to_finish_early[%0d] got %b want 0", k, fin_t); end
            end else begin
                vectors++; if (fin_t !== 1'b1) begin errs++; $display("FAIL to_finish got %b want 1", fin_t); end
                vectors++; if (tmo_t !== 1'b1) begin errs++; $display("FAIL to_timeout got %b want 1", tmo_t); end
            end
        end
        rvfi_t = '0;
    endtask

    task automatic test_halt_beats_timeout();
        rdy_t = 1'b0; rst_t = 1'b1; tick(); rst_t = 1'b0;
        rdy_t = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            rvfi_t = '0;
            if (k == 10) rvfi_t[0] = mk(306, ECALL, 2'b11);
            tick();
            if (k == 10) begin
                vectors++; if (vld_t !== 1'b1 || tr_t.order !== 64'd306) begin errs++; $display("FAIL hbt_entry got vld=%b order=%0d want vld=1 order=306", vld_t, tr_t.order); end
                vectors++; if (fin_t !== 1'b0) begin errs++; $display("FAIL hbt_early got %b want 0", fin_t); end
            end
        end
        rvfi_t = '0;
        vectors++; if (fin_t !== 1'b1) begin errs++; $display("FAIL hbt_finish got %b want 1", fin_t); end
        vectors++; if (tmo_t !== 1'b0) begin errs++; $display("FAIL hbt_timeout got %b want 0", tmo_t); end
    endtask

    initial begin
        test_reset();
        test_ordering();
        test_backpressure();
        test_full_pop();
        test_halt();
        test_reset_mid_drain();
        test_timeout();
        test_halt_beats_timeout();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
